pc_unit: RTL

Parametrised program-counter unit for the 16-bit CPU. It holds the registered PC and computes the next PC for five operations: sequential increment, conditional relative branch, absolute jump, call and return. Calls and returns use a small hardware return-address stack (RAS). It sits between the decode/branch-resolve logic and instruction fetch, and replaces the bare combinational PC incrementer with a width- and step-generic sequential unit.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_add_n.sv | 32 +++
 rtl/pc_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - OP_W          : width of the op code bus
//   - pc_op_e       : op encodings (codes 5..7 are unassigned and act as PC_NEXT)
//   - pc_full_add   : single-bit full-adder cell used by the ripple adder
package pc_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      PC_NEXT   = 3'd0,
      PC_BRANCH = 3'd1,
      PC_JUMP   = 3'd2,
      PC_CALL   = 3'd3,
      PC_RET    = 3'd4
   } pc_op_e;

   // Returns {carry_out, sum}.
   function automatic logic [1:0] pc_full_add(input logic a, input logic b, input logic cin);
      logic s;
      logic co;
      s  = a ^ b ^ cin;
      co = (a & b) | (cin & (a ^ b));
      return {co, s};
   endfunction

endpackage

// File: rtl/pc_add_n.sv
// pc_add_n: WIDTH-bit ripple-carry adder built from the pc_full_add cell.
// Ports:
//   a, b  in  WIDTH  operands
//   cin   in  1      carry in
//   sum   out WIDTH  a + b + cin modulo 2^WIDTH
//   cout  out 1      carry out of the top bit
module pc_add_n
   import pc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic carry;

   // The carry is threaded through a procedural variable so each bit is one
   // full-adder cell without building a self-referencing carry vector.
   always_comb begin
      carry = cin;
      sum   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {carry, sum[i]} = pc_full_add(a[i], b[i], carry);
      end
      cout = carry;
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with next-PC computation for
// NEXT / BRANCH / JUMP / CALL / RET and a small circular return-address stack.
// Ports:
//   clock      in   1         rising-edge clock
//   reset      in   1         synchronous active-high reset, wins over stall/op
//   stall      in   1         hold all state, force wrap low
//   op         in   OP_W      operation code (pc_op_e; 5..7 behave as NEXT)
//   taken      in   1         branch condition, BRANCH only
//   offset     in   OFFSET_W  signed branch displacement relative to pc
//   target     in   WIDTH     absolute destination for JUMP and CALL
//   pc         out  WIDTH     registered current PC
//   pc_next    out  WIDTH     combinational PC for the next edge (ignores stall/reset)
//   wrap       out  1         registered; last update's sum left the 0..2^WIDTH-1 range
//   ras_empty  out  1         registered; stack holds 0 entries
//   ras_full   out  1         registered; stack holds RAS_DEPTH entries
//   fault      out  1         sticky push-while-full / pop-while-empty, cleared by reset
// OFFSET_W must be smaller than WIDTH; RAS_DEPTH must be a power of two >= 2.
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter int               STEP         = 2,
   parameter int               OFFSET_W     = 8,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic [OP_W-1:0]     op,
   input  logic                taken,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [WIDTH-1:0]    target,
   output logic [WIDTH-1:0]    pc,
   output logic [WIDTH-1:0]    pc_next,
   output logic                wrap,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                fault
);

   localparam int               PTR_W    = $clog2(RAS_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam int               EXT_W    = WIDTH - OFFSET_W;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   // ---------------------------------------------------------------
   // Adders
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] off_sext;
   logic [WIDTH-1:0] inc_sum;
   logic             inc_co;
   logic [WIDTH-1:0] br_sum;
   logic             br_co;
   logic             br_ovf;

   assign off_sext = {{EXT_W{offset[OFFSET_W-1]}}, offset};

   pc_add_n #(.WIDTH(WIDTH)) u_add_inc (
      .a    (pc),
      .b    (STEP_W),
      .cin  (1'b0),
      .sum  (inc_sum),
      .cout (inc_co)
   );

   pc_add_n #(.WIDTH(WIDTH)) u_add_br (
      .a    (pc),
      .b    (off_sext),
      .cin  (1'b0),
      .sum  (br_sum),
      .cout (br_co)
   );

   // Unsigned pc plus a sign-extended offset stays in range exactly when the
   // carry out matches the offset sign (negative offsets must borrow-carry).
   assign br_ovf = br_co ^ offset[OFFSET_W-1];

   // ---------------------------------------------------------------
   // Return-address stack
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_ptr;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] ras_top;
   logic             stack_empty;
   logic             stack_full;

   assign ras_top     = ras_mem[top_ptr];
   assign stack_empty = (count == '0);
   assign stack_full  = (count == CNT_FULL);

   // ---------------------------------------------------------------
   // Next-state decode
   // ---------------------------------------------------------------
   logic             wrap_d;
   logic             push;
   logic             pop;
   logic             set_fault;
   logic [PTR_W-1:0] ptr_n;
   logic [CNT_W-1:0] count_n;

   always_comb begin
      pc_next   = inc_sum;
      wrap_d    = inc_co;
      push      = 1'b0;
      pop       = 1'b0;
      set_fault = 1'b0;
      case (op)
         PC_BRANCH: begin
            if (taken) begin
               pc_next = br_sum;
               wrap_d  = br_ovf;
            end
         end
         PC_JUMP: begin
            pc_next = target;
            wrap_d  = 1'b0;
         end
         PC_CALL: begin
            pc_next   = target;
            wrap_d    = 1'b0;
            push      = 1'b1;
            set_fault = stack_full;
         end
         PC_RET: begin
            wrap_d = 1'b0;
            if (!stack_empty) begin
               pc_next = ras_top;
               pop     = 1'b1;
            end else begin
               set_fault = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // A push onto a full stack advances the pointer onto the oldest entry and
   // overwrites it, so the count saturates while the pointer keeps rotating.
   always_comb begin
      ptr_n   = top_ptr;
      count_n = count;
      if (push) begin
         ptr_n = top_ptr + PTR_W'(1);
         if (!stack_full) begin
            count_n = count + CNT_W'(1);
         end
      end else if (pop) begin
         ptr_n   = top_ptr - PTR_W'(1);
         count_n = count - CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= RESET_VECTOR;
         top_ptr   <= '1;
         count     <= '0;
         wrap      <= 1'b0;
         ras_empty <= 1'b1;
         ras_full  <= 1'b0;
         fault     <= 1'b0;
      end else if (stall) begin
         wrap <= 1'b0;
      end else begin
         pc        <= pc_next;
         top_ptr   <= ptr_n;
         count     <= count_n;
         wrap      <= wrap_d;
         ras_empty <= (count_n == '0);
         ras_full  <= (count_n == CNT_FULL);
         if (set_fault) begin
            fault <= 1'b1;
         end
      end
   end

   // Stack contents carry no reset; only the pointer/count define validity.
   always_ff @(posedge clock) begin
      if (!reset && !stall && push) begin
         ras_mem[ptr_n] <= inc_sum;
      end
   end

endmodule
